// File: rtl/daccess_align_unit.sv
// rtl/daccess_align_unit.sv - data-access aligner: splits, merges and extends pipeline accesses onto an aligned bus
// Optional feature macro: DACCESS_RMW_EN (stores become read-modify-write on a strobe-less memory)
module daccess_align_unit #(
  parameter int BUS_BYTES = 4,
  parameter int ADDR_W    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dreq_valid,
  output logic                   dreq_ready,
  input  logic [ADDR_W-1:0]      dreq_addr,
  input  logic                   dreq_wen,
  input  logic [1:0]             dreq_size,
  input  logic                   dreq_signed,
  input  logic [8*BUS_BYTES-1:0] dreq_wdata,
  output logic                   dresp_valid,
  input  logic                   dresp_ready,
  output logic [ADDR_W-1:0]      dresp_addr,
  output logic [8*BUS_BYTES-1:0] dresp_rdata,
  output logic                   memreq_valid,
  input  logic                   memreq_ready,
  output logic [ADDR_W-1:0]      memreq_addr,
  output logic                   memreq_wen,
  output logic [BUS_BYTES-1:0]   memreq_wstrb,
  output logic [8*BUS_BYTES-1:0] memreq_wdata,
  input  logic                   memresp_valid,
  input  logic [8*BUS_BYTES-1:0] memresp_rdata
);
  localparam int BW    = 8 * BUS_BYTES;
  localparam int OFF_W = $clog2(BUS_BYTES);

  typedef enum logic [3:0] {IDLE, RD1, RW1, RD2, RW2, MERGE, RESP, WR1, WR2} state_t;
  state_t state, state_nx;

  logic [ADDR_W-1:0]      addr_q, base_q, base_hi;
  logic [OFF_W-1:0]       off_q;
  logic [3:0]             nbytes_q;
  logic                   wen_q, signed_q, two_q, live_q;
  logic [2*BW-1:0]        wdata_q;
  logic [2*BUS_BYTES-1:0] strb_q;
  logic [BW-1:0]          rd1_q, rd2_q, rdata_q;

  logic [OFF_W-1:0]       req_off;
  logic [3:0]             req_nbytes;
  logic                   req_two, req_rmw;
  logic [2*BUS_BYTES-1:0] strb_mask, req_strb;
  logic [2*BW-1:0]        req_wdata;

  logic [2*BW-1:0]        rd_cat, wr_merge;
  logic [BW-1:0]          rd_sh, load_ext;
  logic                   sign_bit;

  assign base_hi = base_q + ADDR_W'(BUS_BYTES);

  // Decode the incoming request: clamped size, bus offset, beat count, and store data/strobes shifted into a two-beat window
  always_comb begin
    req_off    = dreq_addr[OFF_W-1:0];
    req_nbytes = 4'd1 << dreq_size;
    if (req_nbytes > 4'(BUS_BYTES)) req_nbytes = 4'(BUS_BYTES);
    req_two    = (5'(req_off) + 5'(req_nbytes)) > 5'(BUS_BYTES);
    for (int i = 0; i < 2*BUS_BYTES; i++) strb_mask[i] = (5'(i) < 5'(req_nbytes));
    req_strb   = strb_mask << req_off;
    req_wdata  = {{BW{1'b0}}, dreq_wdata} << {req_off, 3'b000};
`ifdef DACCESS_RMW_EN
    // Only an aligned full-width store can skip the read on a strobe-less memory
    req_rmw    = dreq_wen && !((req_off == '0) && (req_nbytes == 4'(BUS_BYTES)));
`else
    req_rmw    = 1'b0;
`endif
  end

  // Merge the captured beats: shifted/extended load result and store bytes overlaid onto read data
  always_comb begin
    rd_cat   = {rd2_q, rd1_q};
    rd_sh    = BW'(rd_cat >> {off_q, 3'b000});
    sign_bit = 1'b0;
    for (int i = 0; i < BUS_BYTES; i++)
      if (4'(i) == nbytes_q - 4'd1) sign_bit = rd_sh[8*i+7];
    for (int i = 0; i < BUS_BYTES; i++)
      load_ext[8*i +: 8] = (4'(i) < nbytes_q) ? rd_sh[8*i +: 8] : {8{signed_q & sign_bit}};
    for (int i = 0; i < 2*BUS_BYTES; i++)
      wr_merge[8*i +: 8] = strb_q[i] ? wdata_q[8*i +: 8] : rd_cat[8*i +: 8];
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state and output decode; outputs depend on registered state only
  always_comb begin
    state_nx     = state;
    dreq_ready   = 1'b0;
    dresp_valid  = 1'b0;
    dresp_addr   = '0;
    dresp_rdata  = '0;
    memreq_valid = 1'b0;
    memreq_addr  = '0;
    memreq_wen   = 1'b0;
    memreq_wstrb = '0;
    memreq_wdata = '0;
    case (state)
      IDLE: begin
        dreq_ready = live_q;
        if (dreq_valid && live_q) state_nx = (!dreq_wen || req_rmw) ? RD1 : WR1;
      end
      RD1: begin
        memreq_valid = 1'b1;
        memreq_addr  = base_q;
        memreq_wstrb = '1;
        if (memreq_ready) state_nx = RW1;
      end
      RW1: if (memresp_valid) state_nx = two_q ? RD2 : MERGE;
      RD2: begin
        memreq_valid = 1'b1;
        memreq_addr  = base_hi;
        memreq_wstrb = '1;
        if (memreq_ready) state_nx = RW2;
      end
      RW2: if (memresp_valid) state_nx = MERGE;
      MERGE: state_nx = wen_q ? WR1 : RESP;
      RESP: begin
        dresp_valid = 1'b1;
        dresp_addr  = addr_q;
        dresp_rdata = rdata_q;
        if (dresp_ready) state_nx = IDLE;
      end
      WR1: begin
        memreq_valid = 1'b1;
        memreq_wen   = 1'b1;
        memreq_addr  = base_q;
`ifdef DACCESS_RMW_EN
        memreq_wstrb = '1;
`else
        memreq_wstrb = strb_q[BUS_BYTES-1:0];
`endif
        memreq_wdata = wdata_q[BW-1:0];
        if (memreq_ready) state_nx = two_q ? WR2 : IDLE;
      end
      WR2: begin
        memreq_valid = 1'b1;
        memreq_wen   = 1'b1;
        memreq_addr  = base_hi;
`ifdef DACCESS_RMW_EN
        memreq_wstrb = '1;
`else
        memreq_wstrb = strb_q[2*BUS_BYTES-1:BUS_BYTES];
`endif
        memreq_wdata = wdata_q[2*BW-1:BW];
        if (memreq_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: capture on accept, save beats, form merged result; live_q keeps dreq_ready low while in reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live_q   <= 1'b0;
      addr_q   <= '0;
      base_q   <= '0;
      off_q    <= '0;
      nbytes_q <= '0;
      wen_q    <= 1'b0;
      signed_q <= 1'b0;
      two_q    <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      rdata_q  <= '0;
    end else begin
      live_q <= 1'b1;
      case (state)
        IDLE: if (dreq_valid && live_q) begin
          addr_q   <= dreq_addr;
          base_q   <= {dreq_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          off_q    <= req_off;
          nbytes_q <= req_nbytes;
          wen_q    <= dreq_wen;
          signed_q <= dreq_signed;
          two_q    <= req_two;
          wdata_q  <= req_wdata;
          strb_q   <= req_strb;
        end
        RW1: if (memresp_valid) rd1_q <= memresp_rdata;
        RW2: if (memresp_valid) rd2_q <= memresp_rdata;
        MERGE: begin
          if (wen_q) wdata_q <= wr_merge;
          else       rdata_q <= load_ext;
        end
        default: ;
      endcase
    end
  end
endmodule
